reg_file: RTL and testbench

- 32-entry by 32-bit integer register file for the RV32I core: two combinational read ports and one synchronous write port.
- It sits between decode, which supplies the source and destination indices, and execute/writeback, which consumes the read data and supplies the write data.
- Entry 0 (x0) is hardwired to zero.

---
 rtl/rf_pkg.sv | 11 +
 rtl/reg_file_rd_port.sv | 41 ++++
 rtl/reg_file.sv | 48 ++++
 tb/tb_reg_file.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared constants and types for the RV32I integer register file.
package rf_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned ADDR_W  = 5;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_rd_port.sv
// Combinational read port: x0 zeroing plus optional write-to-read forwarding.
// Forwarding is compiled in when RF_BYPASS_EN is defined.
module reg_file_rd_port
    import rf_pkg::*;
(
    input  reg_data_t regs [REG_NUM],
    input  reg_idx_t  reg_s,
    input  logic      write_e,
    input  reg_idx_t  rd,
    input  reg_data_t write_d,
    output reg_data_t reg_d
);

`ifdef RF_BYPASS_EN
    logic fwd;

    // rd=0 is never forwarded, so x0 reads stay zero even while being written.
    assign fwd = write_e && (rd != '0) && (rd == reg_s);

    always_comb begin
        reg_d = '0;
        if (fwd) begin
            reg_d = write_d;
        end else if (reg_s != '0) begin
            reg_d = regs[reg_s];
        end
    end
`else
    logic unused_bypass;

    assign unused_bypass = ^{write_e, rd, write_d};

    always_comb begin
        reg_d = '0;
        if (reg_s != '0) begin
            reg_d = regs[reg_s];
        end
    end
`endif

endmodule

// File: rtl/reg_file.sv
// 32x32 RV32I register file: two combinational read ports, one synchronous write port.
// Optional same-cycle write forwarding is enabled by defining RF_BYPASS_EN.
module reg_file
    import rf_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  reg_idx_t  reg_s1,
    input  reg_idx_t  reg_s2,
    input  reg_idx_t  rd,
    input  logic      write_e,
    input  reg_data_t write_d,
    output reg_data_t reg_d1,
    output reg_data_t reg_d2
);

    reg_data_t regs_q [REG_NUM];

    // Entry 0 is only ever cleared; the read ports also mask it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(REG_NUM); i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_e && (rd != '0)) begin
            regs_q[rd] <= write_d;
        end
    end

    reg_file_rd_port u_rd_port1 (
        .regs    (regs_q),
        .reg_s   (reg_s1),
        .write_e (write_e),
        .rd      (rd),
        .write_d (write_d),
        .reg_d   (reg_d1)
    );

    reg_file_rd_port u_rd_port2 (
        .regs    (regs_q),
        .reg_s   (reg_s2),
        .write_e (write_e),
        .rd      (rd),
        .write_d (write_d),
        .reg_d   (reg_d2)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table plus reset/bypass sequences.
module tb_reg_file;
    import rf_pkg::*;

    logic      clk;
    logic      rst;
    reg_idx_t  reg_s1;
    reg_idx_t  reg_s2;
    reg_idx_t  rd;
    logic      write_e;
    reg_data_t write_d;
    reg_data_t reg_d1;
    reg_data_t reg_d2;

    int checks;
    int errors;

    reg_file dut (
        .clk     (clk),
        .rst     (rst),
        .reg_s1  (reg_s1),
        .reg_s2  (reg_s2),
        .rd      (rd),
        .write_e (write_e),
        .write_d (write_d),
        .reg_d1  (reg_d1),
        .reg_d2  (reg_d2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic      we;
        reg_idx_t  rd;
        reg_data_t wd;
        reg_idx_t  s1;
        reg_idx_t  s2;
        reg_data_t exp1;
        reg_data_t exp2;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    reg_data_t bypass_exp;

    initial begin
        checks = 0;
        errors = 0;
`ifdef RF_BYPASS_EN
        bypass_exp = 32'd123;
`else
        bypass_exp = 32'd0;
`endif
        // Write/read pairs; expectations are the read values after the write edge.
        vecs[0] = '{1'b1, 5'd4,  32'd42,         5'd4,  5'd0,  32'd42,         32'd0};
        vecs[1] = '{1'b1, 5'd2,  32'd99,         5'd2,  5'd4,  32'd99,         32'd42};
        vecs[2] = '{1'b1, 5'd0,  32'hDEADBEEF,   5'd0,  5'd2,  32'd0,          32'd99};
        vecs[3] = '{1'b0, 5'd4,  32'd7,          5'd4,  5'd4,  32'd42,         32'd42};
        vecs[4] = '{1'b1, 5'd31, 32'hFFFFFFFF,   5'd31, 5'd1,  32'hFFFFFFFF,   32'd0};
        vecs[5] = '{1'b1, 5'd1,  32'd1,          5'd1,  5'd31, 32'd1,          32'hFFFFFFFF};
        vecs[6] = '{1'b1, 5'd4,  32'd5,          5'd4,  5'd2,  32'd5,          32'd99};
        vecs[7] = '{1'b0, 5'd2,  32'd0,          5'd2,  5'd4,  32'd99,         32'd5};

        // Reset state, and a write attempted during reset must be dropped.
        rst = 1'b1; write_e = 1'b1; rd = 5'd3; write_d = 32'd77;
        reg_s1 = 5'd4; reg_s2 = 5'd31;
        #1;
        check("reset_d1", reg_d1, 32'd0);
        check("reset_d2", reg_d2, 32'd0);
        @(negedge clk);
        @(negedge clk);
        write_e = 1'b0; reg_s1 = 5'd3;
        rst = 1'b0;
        #1;
        check("write_in_reset_ignored", reg_d1, 32'd0);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            write_e = vecs[i].we; rd = vecs[i].rd; write_d = vecs[i].wd;
            reg_s1 = vecs[i].s1; reg_s2 = vecs[i].s2;
            @(posedge clk);
            #1;
            write_e = 1'b0;
            check($sformatf("vec%0d_d1", i), reg_d1, vecs[i].exp1);
            check($sformatf("vec%0d_d2", i), reg_d2, vecs[i].exp2);
        end

        // Same-cycle read/write of index 5.
        @(negedge clk);
        write_e = 1'b1; rd = 5'd5; write_d = 32'd123; reg_s1 = 5'd5; reg_s2 = 5'd5;
        #4;
        check("same_cycle_pre_edge_d1", reg_d1, bypass_exp);
        check("same_cycle_pre_edge_d2", reg_d2, bypass_exp);
        @(posedge clk);
        #1;
        write_e = 1'b0;
        check("same_cycle_post_edge", reg_d1, 32'd123);

        // x0 is never forwarded.
        @(negedge clk);
        write_e = 1'b1; rd = 5'd0; write_d = 32'h12345678; reg_s1 = 5'd0;
        #1;
        check("x0_no_forward", reg_d1, 32'd0);
        write_e = 1'b0;

        // Asynchronous reset pulse between edges.
        @(negedge clk);
        reg_s1 = 5'd2; reg_s2 = 5'd4;
        #1;
        check("pre_reset_d1", reg_d1, 32'd99);
        rst = 1'b1;
        #1;
        check("async_reset_d1", reg_d1, 32'd0);
        check("async_reset_d2", reg_d2, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_reset_hold", reg_d1, 32'd0);

        // First write after reset lands normally.
        @(negedge clk);
        write_e = 1'b1; rd = 5'd2; write_d = 32'd55;
        @(posedge clk);
        #1;
        write_e = 1'b0;
        check("write_after_reset_d1", reg_d1, 32'd55);
        check("write_after_reset_d2", reg_d2, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
